// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges EXU and LSU results onto the single regfile write port.
// LSU wins by default; a saturating starvation counter forces an EXU grant after STARVE_MAX LSU wins.
`ifndef XLEN
`define XLEN 32
`endif
`ifndef REG_IDX_WIDTH
`define REG_IDX_WIDTH 5
`endif
`ifndef REG_X0
`define REG_X0 {`REG_IDX_WIDTH{1'b0}}
`endif

module wb_arbiter #(
   parameter int STARVE_MAX = 4
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      exu_valid_i,
   output logic                      exu_ready_o,
   input  logic [`REG_IDX_WIDTH-1:0] exu_rd_idx_i,
   input  logic [`XLEN-1:0]          exu_wdata_i,
   input  logic                      lsu_valid_i,
   output logic                      lsu_ready_o,
   input  logic [`REG_IDX_WIDTH-1:0] lsu_rd_idx_i,
   input  logic [`XLEN-1:0]          lsu_wdata_i,
   output logic                      rd_en_o,
   output logic [`REG_IDX_WIDTH-1:0] rd_idx_o,
   output logic [`XLEN-1:0]          rd_wdata_o,
   output logic                      wb_src_o
);
   localparam int               CNT_W     = $clog2(STARVE_MAX + 1);
   localparam logic [CNT_W-1:0] L_CNT_MAX = CNT_W'(STARVE_MAX);

   logic [CNT_W-1:0]          r_starve_cnt;
   logic                      r_rd_en;
   logic [`REG_IDX_WIDTH-1:0] r_rd_idx;
   logic [`XLEN-1:0]          r_rd_wdata;
   logic                      r_wb_src;

   logic                      w_starved;
   logic                      w_exu_gnt;
   logic                      w_lsu_gnt;
   logic                      w_any_gnt;
   logic [CNT_W-1:0]          w_cnt_nxt;
   logic [`REG_IDX_WIDTH-1:0] w_gnt_idx;
   logic [`XLEN-1:0]          w_gnt_wdata;

   // Grants are gated by rst_n so nothing is handshaken while reset is held.
   always_comb begin
      w_starved   = (r_starve_cnt == L_CNT_MAX);
      w_exu_gnt   = rst_n && exu_valid_i && (!lsu_valid_i || w_starved);
      w_lsu_gnt   = rst_n && lsu_valid_i && !(exu_valid_i && w_starved);
      w_any_gnt   = w_exu_gnt || w_lsu_gnt;
      w_gnt_idx   = w_lsu_gnt ? lsu_rd_idx_i : exu_rd_idx_i;
      w_gnt_wdata = w_lsu_gnt ? lsu_wdata_i  : exu_wdata_i;
      w_cnt_nxt   = '0;
      if (w_lsu_gnt && exu_valid_i) begin
         w_cnt_nxt = w_starved ? r_starve_cnt : r_starve_cnt + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_starve_cnt <= '0;
         r_rd_en      <= 1'b0;
         r_rd_idx     <= '0;
         r_rd_wdata   <= '0;
         r_wb_src     <= 1'b0;
      end else begin
         r_starve_cnt <= w_cnt_nxt;
         r_rd_en      <= w_any_gnt && (w_gnt_idx != `REG_X0);
         // Payload holds on idle cycles to avoid toggling the regfile write bus.
         if (w_any_gnt) begin
            r_rd_idx   <= w_gnt_idx;
            r_rd_wdata <= w_gnt_wdata;
            r_wb_src   <= w_lsu_gnt;
         end
      end
   end

   assign exu_ready_o = w_exu_gnt;
   assign lsu_ready_o = w_lsu_gnt;
   assign rd_en_o     = r_rd_en;
   assign rd_idx_o    = r_rd_idx;
   assign rd_wdata_o  = r_rd_wdata;
   assign wb_src_o    = r_wb_src;

endmodule
